// File: rtl/div128x64_m.sv
// Sequential unsigned 128/64 restoring divider, one quotient bit per clock.
// Outputs are latched in DONE and held there; error cases finish after a single busy cycle.
module div128x64_m (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] a,
  input  logic [63:0]  b,
  output logic         ready,
  output logic [63:0]  q,
  output logic [63:0]  r,
  output logic         div_zero,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] dvsr, rem, quo;
  logic [5:0]  cnt;
  logic        dz_pend, ov_pend;
  logic [64:0] t;
  logic [63:0] diff;
  logic        ge;
  logic        b_zero, hi_ovf;

  assign b_zero = (b == 64'd0);
  assign hi_ovf = (a[127:64] >= b);
  assign ready  = (state == IDLE);

  // rem < dvsr before each step, so t - dvsr always fits in 64 bits when taken.
  always_comb begin
    t    = {rem, quo[63]};
    ge   = (t >= {1'b0, dvsr});
    diff = t[63:0] - dvsr;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (b_zero || hi_ovf) state_nxt = DONE;
          else                  state_nxt = RUN;
        end
      end
      RUN:     if (cnt == 6'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      q        <= 64'd0;
      r        <= 64'd0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      dz_pend  <= 1'b0;
      ov_pend  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            dvsr    <= b;
            rem     <= a[127:64];
            quo     <= a[63:0];
            dz_pend <= b_zero;
            ov_pend <= !b_zero && hi_ovf;
            cnt     <= 6'd63;
          end
        end
        RUN: begin
          rem <= ge ? diff : t[63:0];
          quo <= {quo[62:0], ge};
          cnt <= cnt - 6'd1;
        end
        DONE: begin
          // Error cases: quo still holds a[63:0] and rem holds a[127:64].
          q        <= (dz_pend || ov_pend) ? {64{1'b1}} : quo;
          r        <= dz_pend ? quo : rem;
          div_zero <= dz_pend;
          ovf      <= ov_pend;
        end
        default: ;
      endcase
    end
  end

endmodule
